// File: rtl/upsample_pkg.sv
// ============================================================================
//  upsample_pkg : shared FSM encoding, up_mode codes and tile helpers
//  Revision: 1.0
// ============================================================================
`default_nettype none

package upsample_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCEPT = 2'd1,
    ST_WRITE  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam logic [1:0] UP_X1 = 2'd0;
  localparam logic [1:0] UP_X2 = 2'd1;
  localparam logic [1:0] UP_X4 = 2'd2;

  // Code 3 is reserved and behaves as x1.
  function automatic logic [2:0] mode_to_factor(input logic [1:0] mode);
    case (mode)
      UP_X1:   return 3'd1;
      UP_X2:   return 3'd2;
      UP_X4:   return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  // Number of populated lanes in column tile 'tile' of a row.
  function automatic int valid_lanes(input int ofm_size, input int sys, input int tile);
    int rem;
    rem = ofm_size - tile * sys;
    return (rem < sys) ? rem : sys;
  endfunction

endpackage

`default_nettype wire

// File: rtl/upsample_store_addr.sv
// ============================================================================
//  ups_addr_gen : registered OFM address for one upsampled element
//  Revision: 1.0
// ============================================================================
`default_nettype none

module ups_addr_gen #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int OFM_SIZE_CONV = 13,
  parameter int ADDR_WIDTH    = 20,
  parameter int FW            = 7,
  parameter int RW            = 4,
  parameter int TW            = 1,
  parameter int LW            = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            factor,
  input  logic [FW-1:0]         filter,
  input  logic [RW-1:0]         row,
  input  logic [TW-1:0]         tile,
  input  logic [LW-1:0]         lane,
  input  logic [1:0]            dy,
  input  logic [1:0]            dx,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam logic [ADDR_WIDTH-1:0] OFM_X1   = ADDR_WIDTH'(OFM_SIZE_CONV);
  localparam logic [ADDR_WIDTH-1:0] OFM_X2   = ADDR_WIDTH'(2 * OFM_SIZE_CONV);
  localparam logic [ADDR_WIDTH-1:0] OFM_X4   = ADDR_WIDTH'(4 * OFM_SIZE_CONV);
  localparam logic [ADDR_WIDTH-1:0] PLANE_X1 = ADDR_WIDTH'(OFM_SIZE_CONV * OFM_SIZE_CONV);
  localparam logic [ADDR_WIDTH-1:0] PLANE_X2 = ADDR_WIDTH'(4 * OFM_SIZE_CONV * OFM_SIZE_CONV);
  localparam logic [ADDR_WIDTH-1:0] PLANE_X4 = ADDR_WIDTH'(16 * OFM_SIZE_CONV * OFM_SIZE_CONV);

  logic [ADDR_WIDTH-1:0] ofm;
  logic [ADDR_WIDTH-1:0] plane;
  logic [1:0]            fshift;
  logic [ADDR_WIDTH-1:0] row_term;
  logic [ADDR_WIDTH-1:0] col_term;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [ADDR_WIDTH-1:0] addr_q;

  always_comb begin
    ofm    = OFM_X1;
    plane  = PLANE_X1;
    fshift = 2'd0;
    case (factor)
      3'd2: begin ofm = OFM_X2; plane = PLANE_X2; fshift = 2'd1; end
      3'd4: begin ofm = OFM_X4; plane = PLANE_X4; fshift = 2'd2; end
      default: ;
    endcase
    // F is a power of two, so scaling row and column by F is a shift.
    row_term = (ADDR_WIDTH'(row) << fshift) + ADDR_WIDTH'(dy);
    col_term = ((ADDR_WIDTH'(tile) * ADDR_WIDTH'(SYSTOLIC_SIZE) + ADDR_WIDTH'(lane)) << fshift)
               + ADDR_WIDTH'(dx);
    addr_d   = ADDR_WIDTH'(filter) * plane + row_term * ofm + col_term;
  end

  always_ff @(posedge clk) begin
    if (rst) addr_q <= '0;
    else     addr_q <= addr_d;
  end

  assign addr = addr_q;

endmodule

`default_nettype wire

// File: rtl/upsample_store.sv
// ============================================================================
//  upsample_store : accepts conv output tiles and writes them nearest-neighbour
//                   upsampled (x1/x2/x4) into OFM memory, one element per cycle
//  Revision: 1.0
// ============================================================================
`default_nettype none

module upsample_store
  import upsample_pkg::*;
#(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int OFM_SIZE_CONV = 13,
  parameter int NO_FILTER     = 128,
  parameter int ADDR_WIDTH    = 20
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [1:0]                        up_mode,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] in_data,
  output logic                              wr_en,
  output logic [ADDR_WIDTH-1:0]             wr_addr,
  output logic [DATA_WIDTH-1:0]             wr_data,
  output logic                              done
);

  localparam int NO_TILING_PER_LINE = (OFM_SIZE_CONV + SYSTOLIC_SIZE - 1) / SYSTOLIC_SIZE;
  localparam int FW = (NO_FILTER > 1)          ? $clog2(NO_FILTER)          : 1;
  localparam int RW = (OFM_SIZE_CONV > 1)      ? $clog2(OFM_SIZE_CONV)      : 1;
  localparam int TW = (NO_TILING_PER_LINE > 1) ? $clog2(NO_TILING_PER_LINE) : 1;
  localparam int LW = (SYSTOLIC_SIZE > 1)      ? $clog2(SYSTOLIC_SIZE)      : 1;

  state_e                             state_q, state_d;
  logic [2:0]                         factor_q, factor_d;
  logic [FW-1:0]                      filter_q, filter_d;
  logic [RW-1:0]                      row_q, row_d;
  logic [TW-1:0]                      tile_q, tile_d;
  logic [LW-1:0]                      lane_q, lane_d;
  logic [1:0]                         dy_q, dy_d;
  logic [1:0]                         dx_q, dx_d;
  logic [SYSTOLIC_SIZE*DATA_WIDTH-1:0] data_q, data_d;

  int   v_lanes;
  logic dx_last, dy_last, lane_last, tile_last, row_last, filter_last;

  assign v_lanes     = valid_lanes(OFM_SIZE_CONV, SYSTOLIC_SIZE, int'(tile_q));
  assign dx_last     = ({1'b0, dx_q} == factor_q - 3'd1);
  assign dy_last     = ({1'b0, dy_q} == factor_q - 3'd1);
  assign lane_last   = (int'(lane_q)   == v_lanes - 1);
  assign tile_last   = (int'(tile_q)   == NO_TILING_PER_LINE - 1);
  assign row_last    = (int'(row_q)    == OFM_SIZE_CONV - 1);
  assign filter_last = (int'(filter_q) == NO_FILTER - 1);

  always_comb begin
    state_d  = state_q;
    factor_d = factor_q;
    filter_d = filter_q;
    row_d    = row_q;
    tile_d   = tile_q;
    lane_d   = lane_q;
    dy_d     = dy_q;
    dx_d     = dx_q;
    data_d   = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ACCEPT;
          factor_d = mode_to_factor(up_mode);
          filter_d = '0;
          row_d    = '0;
          tile_d   = '0;
          lane_d   = '0;
          dy_d     = '0;
          dx_d     = '0;
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Odometer: dx fastest, then dy, lane, tile, row, filter.
        if (!dx_last) dx_d = dx_q + 2'd1;
        else begin
          dx_d = '0;
          if (!dy_last) dy_d = dy_q + 2'd1;
          else begin
            dy_d = '0;
            if (!lane_last) lane_d = lane_q + 1'b1;
            else begin
              lane_d  = '0;
              state_d = ST_ACCEPT;
              if (!tile_last) tile_d = tile_q + 1'b1;
              else begin
                tile_d = '0;
                if (!row_last) row_d = row_q + 1'b1;
                else begin
                  row_d = '0;
                  if (!filter_last) filter_d = filter_q + 1'b1;
                  else begin
                    filter_d = '0;
                    state_d  = ST_FINISH;
                  end
                end
              end
            end
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      factor_q <= 3'd1;
      filter_q <= '0;
      row_q    <= '0;
      tile_q   <= '0;
      lane_q   <= '0;
      dy_q     <= '0;
      dx_q     <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      factor_q <= factor_d;
      filter_q <= filter_d;
      row_q    <= row_d;
      tile_q   <= tile_d;
      lane_q   <= lane_d;
      dy_q     <= dy_d;
      dx_q     <= dx_d;
      data_q   <= data_d;
    end
  end

  // Fed with next-state indices so the registered address lines up with wr_en.
  ups_addr_gen #(
    .SYSTOLIC_SIZE (SYSTOLIC_SIZE),
    .OFM_SIZE_CONV (OFM_SIZE_CONV),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .FW            (FW),
    .RW            (RW),
    .TW            (TW),
    .LW            (LW)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .factor (factor_d),
    .filter (filter_d),
    .row    (row_d),
    .tile   (tile_d),
    .lane   (lane_d),
    .dy     (dy_d),
    .dx     (dx_d),
    .addr   (wr_addr)
  );

  assign in_ready = (state_q == ST_ACCEPT);
  assign wr_en    = (state_q == ST_WRITE);
  assign done     = (state_q == ST_FINISH);
  assign wr_data  = data_q[int'(lane_q) * DATA_WIDTH +: DATA_WIDTH];

endmodule

`default_nettype wire

// File: tb/tb_upsample_store.sv
// ============================================================================
//  tb_upsample_store : directed self-checking bench for upsample_store
//  Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_upsample_store;

  localparam int SYS = 16, DW = 16, OFM = 13, NF = 128, AW = 20;
  localparam int DW2 = 8, OFM2 = 20, AW2 = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic              start = 1'b0;
  logic [1:0]        up_mode = 2'd0;
  logic              in_valid = 1'b0;
  logic [SYS*DW-1:0] in_data = '0;
  logic              in_ready, wr_en, done;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;

  logic               start2 = 1'b0;
  logic [1:0]         up_mode2 = 2'd0;
  logic               in_valid2 = 1'b0;
  logic [SYS*DW2-1:0] in_data2 = '0;
  logic               in_ready2, wr_en2, done2;
  logic [AW2-1:0]     wr_addr2;
  logic [DW2-1:0]     wr_data2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  upsample_store #(
    .SYSTOLIC_SIZE(SYS), .DATA_WIDTH(DW), .OFM_SIZE_CONV(OFM), .NO_FILTER(NF), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .up_mode(up_mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .done(done)
  );

  upsample_store #(
    .SYSTOLIC_SIZE(SYS), .DATA_WIDTH(DW2), .OFM_SIZE_CONV(OFM2), .NO_FILTER(1), .ADDR_WIDTH(AW2)
  ) dut2 (
    .clk(clk), .rst(rst), .start(start2), .up_mode(up_mode2), .in_valid(in_valid2),
    .in_ready(in_ready2), .in_data(in_data2), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .done(done2)
  );

  function automatic logic [DW-1:0] pat(input int f, input int row, input int k);
    return DW'(((f & 255) << 8) | ((row & 15) << 4) | (k & 15));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (wr_en !== 1'b0)    begin errors++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (wr_addr !== '0)    begin errors++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    checks++; if (wr_data !== '0)    begin errors++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if ({in_ready2, wr_en2, done2} !== 3'b000) begin errors++; $display("FAIL reset_dut2 got=%b exp=000", {in_ready2, wr_en2, done2}); end
    rst = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL idle_no_ready got=%b exp=0", in_ready); end
  endtask

  // x2, filter 0 row 0: lane0=5 lands at 0,1,26,27; a start pulse mid-burst is ignored.
  task automatic test_x2_first_tile();
    int n;
    int exp_addr;
    n = 0;
    up_mode = 2'd1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL x2_ready got=%b exp=1", in_ready); end
    for (int k = 0; k < SYS; k++) in_data[k*DW +: DW] = DW'(5 + k * 257);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_data  = '1;
    for (int lane = 0; lane < 13; lane++)
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++) begin
          exp_addr = dy * 26 + lane * 2 + dx;
          start = (lane == 5 && dy == 0 && dx == 0);
          checks++;
          if ({wr_en, in_ready, done, wr_addr, wr_data} !== {3'b100, AW'(exp_addr), DW'(5 + lane * 257)}) begin
            errors++;
            $display("FAIL x2_write lane=%0d dy=%0d dx=%0d got en=%b rdy=%b done=%b addr=%0d data=%h exp addr=%0d data=%h",
                     lane, dy, dx, wr_en, in_ready, done, wr_addr, wr_data, exp_addr, DW'(5 + lane * 257));
          end
          if (wr_en === 1'b1) n++;
          tick();
        end
    start = 1'b0;
    checks++; if (n !== 52) begin errors++; $display("FAIL x2_write_count got=%0d exp=52", n); end
    checks++; if ({in_ready, wr_en} !== 2'b10) begin errors++; $display("FAIL x2_back_to_accept got rdy,en=%b exp=10", {in_ready, wr_en}); end
  endtask

  // Second tile (row 1) is interrupted by reset after five writes.
  task automatic test_rst_abort();
    int exp_addr [5];
    exp_addr = '{52, 53, 78, 79, 54};
    for (int k = 0; k < SYS; k++) in_data[k*DW +: DW] = pat(0, 1, k);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({wr_en, wr_addr} !== {1'b1, AW'(exp_addr[i])}) begin
        errors++;
        $display("FAIL abort_pre_write i=%0d got en=%b addr=%0d exp en=1 addr=%0d", i, wr_en, wr_addr, exp_addr[i]);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({in_ready, wr_en, done, wr_addr, wr_data} !== '0) begin
      errors++;
      $display("FAIL abort_outputs got rdy=%b en=%b done=%b addr=%0d data=%h exp all 0", in_ready, wr_en, done, wr_addr, wr_data);
    end
    rst = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({in_ready, wr_en} !== 2'b00) begin errors++; $display("FAIL abort_needs_start i=%0d got rdy,en=%b exp=00", i, {in_ready, wr_en}); end
    end
    in_valid = 1'b0;
  endtask

  // x1 full layer with in_valid held high; data for the next tile is presented during each burst.
  task automatic test_x1_full_layer();
    int writes;
    int nf, nr, exp_addr;
    writes  = 0;
    up_mode = 2'd0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < SYS; k++) in_data[k*DW +: DW] = pat(0, 0, k);
    in_valid = 1'b1;
    for (int f = 0; f < NF; f++)
      for (int row = 0; row < OFM; row++) begin
        checks++;
        if ({in_ready, wr_en} !== 2'b10) begin errors++; $display("FAIL x1_accept f=%0d row=%0d got rdy,en=%b exp=10", f, row, {in_ready, wr_en}); end
        tick();
        nf = (row == OFM - 1) ? f + 1 : f;
        nr = (row == OFM - 1) ? 0 : row + 1;
        for (int k = 0; k < SYS; k++) in_data[k*DW +: DW] = pat(nf, nr, k);
        for (int lane = 0; lane < OFM; lane++) begin
          exp_addr = f * OFM * OFM + row * OFM + lane;
          start = (f == 64 && row == 0 && lane == 3);
          checks++;
          if ({wr_en, in_ready, done, wr_addr, wr_data} !== {3'b100, AW'(exp_addr), pat(f, row, lane)}) begin
            errors++;
            $display("FAIL x1_write f=%0d row=%0d lane=%0d got en=%b rdy=%b done=%b addr=%0d data=%h exp addr=%0d data=%h",
                     f, row, lane, wr_en, in_ready, done, wr_addr, wr_data, exp_addr, pat(f, row, lane));
          end
          if (wr_en === 1'b1) writes++;
          tick();
        end
      end
    start    = 1'b0;
    in_valid = 1'b0;
    checks++; if ({done, wr_en} !== 2'b10) begin errors++; $display("FAIL x1_done got done,en=%b exp=10", {done, wr_en}); end
    checks++; if (writes !== 21632) begin errors++; $display("FAIL x1_total_writes got=%0d exp=21632", writes); end
    tick();
    checks++; if ({done, in_ready, wr_en} !== 3'b000) begin errors++; $display("FAIL x1_after_done got done,rdy,en=%b exp=000", {done, in_ready, wr_en}); end
  endtask

  // OFM 20, x4: tile 1 of row 0 has 4 valid lanes; lane0 at 64..67,144..147,224..227,304..307.
  task automatic test_x4_partial_tile();
    int n;
    int exp_addr;
    up_mode2 = 2'd2;
    start2   = 1'b1;
    tick();
    start2 = 1'b0;
    for (int k = 0; k < SYS; k++) in_data2[k*DW2 +: DW2] = DW2'(k + 1);
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    for (int lane = 0; lane < SYS; lane++)
      for (int dy = 0; dy < 4; dy++)
        for (int dx = 0; dx < 4; dx++) begin
          exp_addr = dy * 80 + lane * 4 + dx;
          checks++;
          if ({wr_en2, wr_addr2, wr_data2} !== {1'b1, AW2'(exp_addr), DW2'(lane + 1)}) begin
            errors++;
            $display("FAIL x4_tile0 lane=%0d dy=%0d dx=%0d got en=%b addr=%0d data=%h exp addr=%0d data=%h",
                     lane, dy, dx, wr_en2, wr_addr2, wr_data2, exp_addr, DW2'(lane + 1));
          end
          tick();
        end
    checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL x4_ready_tile1 got=%b exp=1", in_ready2); end
    for (int k = 0; k < SYS; k++) in_data2[k*DW2 +: DW2] = DW2'(8'hA0 + k);
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    n = 0;
    for (int lane = 0; lane < 4; lane++)
      for (int dy = 0; dy < 4; dy++)
        for (int dx = 0; dx < 4; dx++) begin
          exp_addr = dy * 80 + (16 + lane) * 4 + dx;
          checks++;
          if ({wr_en2, wr_addr2, wr_data2} !== {1'b1, AW2'(exp_addr), DW2'(8'hA0 + lane)}) begin
            errors++;
            $display("FAIL x4_tile1 lane=%0d dy=%0d dx=%0d got en=%b addr=%0d data=%h exp addr=%0d data=%h",
                     lane, dy, dx, wr_en2, wr_addr2, wr_data2, exp_addr, DW2'(8'hA0 + lane));
          end
          if (wr_en2 === 1'b1) n++;
          tick();
        end
    checks++; if (n !== 64) begin errors++; $display("FAIL x4_tile1_count got=%0d exp=64", n); end
    checks++; if ({in_ready2, wr_en2} !== 2'b10) begin errors++; $display("FAIL x4_tile1_end got rdy,en=%b exp=10", {in_ready2, wr_en2}); end
  endtask

  initial begin
    test_reset();
    test_x2_first_tile();
    test_rst_abort();
    test_x1_full_layer();
    test_x4_partial_tile();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
